// File: rtl/eq_serial_ctrl.sv
// Serial equality comparator: walks two WIDTH-bit operands one 2-bit digit per cycle through a single eq2 cell.
// Optional EQ_SERIAL_EARLY_EXIT_EN ends the compare on the first differing digit (same results, shorter latency).

module eq2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       aeqb
);
  assign aeqb = (a == b);
endmodule

module eq_serial_ctrl #(
  parameter  int WIDTH  = 8,
  localparam int DIGITS = WIDTH / 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  output logic                      ready,
  output logic                      busy,
  output logic                      done,
  output logic                      aeqb,
  output logic [$clog2(DIGITS)-1:0] mismatch_idx
);
  localparam int IW = $clog2(DIGITS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    first_idx;
  logic             flag;
  logic             aeqb_q;
  logic [IW-1:0]    midx_q;
  logic             digit_eq;
  logic             hit;
  logic             last;
  logic             leave;

  eq2 u_eq2 (
    .a    (sa[1:0]),
    .b    (sb[1:0]),
    .aeqb (digit_eq)
  );

  assign hit  = ~digit_eq;
  assign last = (idx == IW'(DIGITS - 1));

`ifdef EQ_SERIAL_EARLY_EXIT_EN
  assign leave = last | hit;
`else
  assign leave = last;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      sa        <= '0;
      sb        <= '0;
      idx       <= '0;
      first_idx <= '0;
      flag      <= 1'b0;
      aeqb_q    <= 1'b0;
      midx_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sa        <= a;
            sb        <= b;
            idx       <= '0;
            first_idx <= '0;
            flag      <= 1'b0;
            state     <= S_CMP;
          end
        end
        S_CMP: begin
          sa  <= sa >> 2;
          sb  <= sb >> 2;
          idx <= idx + 1'b1;
          if (hit && !flag) begin
            flag      <= 1'b1;
            first_idx <= idx;
          end
          if (leave) begin
            state  <= S_DONE;
            // Fold in this cycle's compare, since flag/first_idx only land next edge.
            aeqb_q <= ~(flag | hit);
            midx_q <= flag ? first_idx : (hit ? idx : '0);
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready        = (state == S_IDLE);
  assign busy         = (state == S_CMP);
  assign done         = (state == S_DONE);
  assign aeqb         = aeqb_q;
  assign mismatch_idx = midx_q;

endmodule

// File: tb/tb_eq_serial_ctrl.sv
// Scoreboard bench for eq_serial_ctrl (WIDTH=8): expected result and done cycle queued at start, checked on done.
module tb_eq_serial_ctrl;
  localparam int WIDTH  = 8;
  localparam int DIGITS = WIDTH / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       ready;
  logic       busy;
  logic       done;
  logic       aeqb;
  logic [1:0] mismatch_idx;

  always #5 clk = ~clk;

  eq_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .a            (a),
    .b            (b),
    .ready        (ready),
    .busy         (busy),
    .done         (done),
    .aeqb         (aeqb),
    .mismatch_idx (mismatch_idx)
  );

  typedef struct {
    logic       eq;
    logic [1:0] idx;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ndone = 0;
  int last_done = -1;
  int prev_done = -1;

  // cyc = number of edges seen; spec cycle n is the period following edge n-1
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input int k);
    exp_t e;
    e.eq  = 1'b1;
    e.idx = 2'd0;
    e.cyc = k + DIGITS + 1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (x[2*i +: 2] != y[2*i +: 2]) begin
        e.eq  = 1'b0;
        e.idx = 2'(i);
`ifdef EQ_SERIAL_EARLY_EXIT_EN
        e.cyc = k + i + 2;
`endif
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      ndone++;
      prev_done = last_done;
      last_done = cyc + 1;
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        check("aeqb", aeqb, e.eq);
        check("mismatch_idx", mismatch_idx, e.idx);
        check("done_cycle", cyc + 1, e.cyc);
      end
    end
  end

  // Called #1 after an edge with the DUT idle; start is accepted on the next edge.
  task automatic issue(input logic [7:0] x, input logic [7:0] y);
    start = 1'b1;
    a = x;
    b = y;
    @(posedge clk); #1;
    start = 1'b0;
    q.push_back(model(x, y, cyc));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", q.size(), 0);
  endtask

  initial begin
    int n0;
    reset = 1'b1;
    start = 1'b1;
    a = 8'hFF;
    b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aeqb", aeqb, 0);
    check("rst_midx", mismatch_idx, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;

    issue(8'hA5, 8'hA5);
    @(negedge clk);
    check("cmp_busy", busy, 1);
    check("cmp_ready", ready, 0);
    drain();
    issue(8'hA5, 8'hA4);
    drain();
    issue(8'h4C, 8'h0F);
    drain();
    issue(8'h40, 8'h00);
    drain();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] x;
      logic [7:0] y;
      x = 8'($urandom);
      y = (i % 2 == 0) ? x : 8'($urandom);
      issue(x, y);
      drain();
    end

    // held start, operands change mid-compare
    n0 = ndone;
    start = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    @(posedge clk); #1;
    q.push_back(model(8'hFF, 8'hFF, cyc));
    a = 8'h00;
    b = 8'h01;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("held_start_done_count", ndone - n0, 1);

    // back-to-back
    issue(8'h3C, 8'h3C);
    drain();
    issue(8'h12, 8'h12);
    drain();
    check("b2b_spacing", last_done - prev_done, DIGITS + 2);

    // reset mid-compare
    n0 = ndone;
    issue(8'h33, 8'h33);
    @(posedge clk); #1;
    reset = 1'b1;
    q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_ready", ready, 1);
    check("abort_aeqb", aeqb, 0);
    check("abort_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    issue(8'h40, 8'h00);
    drain();
    check("abort_done_count", ndone - n0, 1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
